// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI bus arbiter
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam int DW_DEF = 8;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
module rr_pick
  import spi_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan from ptr upward with wrap; the first set bit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin sharing of one spi_master byte engine
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW      = DW_DEF,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 1024,
  localparam int IW     = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  byte_valid,
  input  logic [NREQ*DW-1:0] byte_data,
  input  logic [NREQ-1:0]  byte_last,
  output logic [NREQ-1:0]  byte_ack,
  output logic [DW-1:0]    rx_data,
  output logic [NREQ-1:0]  rx_valid,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  err,
  output logic             spi_start,
  output logic [DW-1:0]    spi_data_out,
  input  logic [DW-1:0]    spi_data_in,
  input  logic             spi_done,
  output logic [IW-1:0]    cs_sel,
  output logic             busy
);

  localparam int TW = clog2(TIMEOUT + 1);
  localparam int GW = clog2(GAP_CYC + 1);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic          last_flag;
  logic [DW-1:0] data_q;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            own_valid;
  logic            own_last;
  logic            own_req;
  logic [DW-1:0]   own_data;
  logic            accept;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // gnt is one-hot for the owner, so masking with it selects the owner's lane.
  always_comb begin
    own_valid = |(gnt & byte_valid);
    own_last  = |(gnt & byte_last);
    own_req   = |(gnt & req);
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) own_data = byte_data[i*DW +: DW];
    end
  end

  // Acceptance is same-cycle so the requester sees its ack with zero latency;
  // the byte is shown live in OWN and held from the latch during WAIT.
  assign accept       = (state == OWN) && own_valid;
  assign byte_ack     = accept ? gnt : '0;
  assign spi_start    = accept;
  assign spi_data_out = (state == OWN) ? own_data : data_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      cs_sel    <= '0;
      last_flag <= 1'b0;
      data_q    <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= '0;
      err       <= '0;
    end else begin
      rx_valid <= '0;
      err      <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt    <= pick_oh;
            cs_sel <= pick_idx;
            ptr    <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            state  <= OWN;
          end
        end
        OWN: begin
          if (own_valid) begin
            data_q    <= own_data;
            last_flag <= own_last;
            to_cnt    <= '0;
            state     <= WAIT;
          end else if (!own_req) begin
            gnt     <= '0;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        WAIT: begin
          if (spi_done) begin
            rx_data  <= spi_data_in;
            rx_valid <= gnt;
            if (last_flag) begin
              gnt     <= '0;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= OWN;
            end
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            err     <= gnt;
            gnt     <= '0;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - self-checking bench for spi_bus_arbiter
module tb_spi_bus_arbiter;

  localparam int NREQ    = 2;
  localparam int DW      = 8;
  localparam int GAP_CYC = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   byte_valid;
  logic [NREQ*DW-1:0] byte_data;
  logic [NREQ-1:0]   byte_last;
  logic [NREQ-1:0]   byte_ack;
  logic [DW-1:0]     rx_data;
  logic [NREQ-1:0]   rx_valid;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   err;
  logic              spi_start;
  logic [DW-1:0]     spi_data_out;
  logic [DW-1:0]     spi_data_in;
  logic              spi_done;
  logic [0:0]        cs_sel;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  int m_ptr = 0;
  logic [7:0] tx_bytes [8];
  logic [7:0] rx_bytes [8];

  always #5 clk = ~clk;

  spi_bus_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ack(byte_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .gnt(gnt), .err(err), .spi_start(spi_start), .spi_data_out(spi_data_out),
    .spi_data_in(spi_data_in), .spi_done(spi_done), .cs_sel(cs_sel), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner is the first requester found walking upward from the pointer.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (((32'(r) >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  task automatic do_reset;
    rst = 1'b1; req = '0; byte_valid = '0; byte_last = '0; byte_data = '0;
    spi_done = 1'b0; spi_data_in = '0;
    tick;
    tick;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", byte_ack, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_err", err, 0);
    check("rst_start", spi_start, 0);
    check("rst_cs", cs_sel, 0);
    check("rst_rxdata", rx_data, 0);
    check("rst_sdo", spi_data_out, 0);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic gap_phase;
    for (int i = 1; i < GAP_CYC; i++) begin
      tick;
      check("gap_busy", busy, 1);
      check("gap_gnt", gnt, 0);
      check("gap_err", err, 0);
      check("gap_rxv", rx_valid, 0);
    end
    tick;
    check("idle_busy", busy, 0);
    check("idle_gnt", gnt, 0);
  endtask

  // Entered in an IDLE cycle with req already driven.
  task automatic run_txn(input int nb, input bit drop_req);
    int w;
    int d;
    logic [NREQ-1:0] wmask;
    w = model_pick(req);
    m_ptr = (w + 1) % NREQ;
    wmask = NREQ'(1 << w);
    tick;
    check("grant", gnt, 32'(wmask));
    check("cs_sel", cs_sel, w);
    check("busy_own", busy, 1);
    spi_done = 1'b1; spi_data_in = 8'h5A;
    tick;
    spi_done = 1'b0;
    check("stray_done_rxv", rx_valid, 0);
    check("grant_hold", gnt, 32'(wmask));
    for (int b = 0; b < nb; b++) begin
      byte_data = 16'($urandom);
      byte_data[w*DW +: DW] = tx_bytes[b];
      byte_valid = wmask | NREQ'($urandom_range(0, 3));
      byte_last = (b == nb - 1) ? wmask : '0;
      byte_last = byte_last | (NREQ'($urandom_range(0, 3)) & ~wmask);
      #1;
      check("ack", byte_ack, 32'(wmask));
      check("start", spi_start, 1);
      check("sdo", spi_data_out, tx_bytes[b]);
      tick;
      byte_valid = '0;
      #1;
      check("start_wait", spi_start, 0);
      check("ack_wait", byte_ack, 0);
      check("rxv_pulse_end", rx_valid, 0);
      d = $urandom_range(0, 3);
      repeat (d) begin
        tick;
        check("start_wait_n", spi_start, 0);
        check("rxv_wait_n", rx_valid, 0);
      end
      spi_done = 1'b1; spi_data_in = rx_bytes[b];
      tick;
      spi_done = 1'b0;
      check("rx_valid", rx_valid, 32'(wmask));
      check("rx_data", rx_data, rx_bytes[b]);
      if (b != nb - 1) check("gnt_mid", gnt, 32'(wmask));
    end
    if (drop_req) req = req & ~wmask;
    check("gnt_end", gnt, 0);
    check("busy_gap", busy, 1);
    gap_phase;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    do_reset;

    // Single requester, three fixed bytes
    tx_bytes[0] = 8'h0F; tx_bytes[1] = 8'h26; tx_bytes[2] = 8'h93;
    rx_bytes[0] = 8'hA1; rx_bytes[1] = 8'hA2; rx_bytes[2] = 8'hA3;
    tick;
    req = 2'b01;
    run_txn(3, 1'b1);

    // Contention right after reset
    do_reset;
    tick;
    req = 2'b11;
    tx_bytes[0] = 8'h3C; rx_bytes[0] = 8'hC3;
    run_txn(1, 1'b1);
    check("contention_left", req, 2'b10);
    tx_bytes[0] = 8'h77; rx_bytes[0] = 8'h88;
    run_txn(1, 1'b1);

    // Fairness: continuous requests from both sides
    req = 2'b11;
    for (int t = 0; t < 8; t++) begin
      tx_bytes[0] = 8'($urandom); rx_bytes[0] = 8'($urandom);
      run_txn(1, 1'b0);
    end
    req = '0;

    // Timeout with no spi_done
    req = 2'b01;
    w = model_pick(req);
    m_ptr = (w + 1) % NREQ;
    tick;
    check("to_grant", gnt, 32'(1 << w));
    byte_valid = 2'b01; byte_last = 2'b01; byte_data = 16'h00E5;
    #1;
    check("to_ack", byte_ack, 2'b01);
    tick;
    byte_valid = '0;
    repeat (TIMEOUT - 1) begin
      tick;
      check("to_err_early", err, 0);
      check("to_busy", busy, 1);
    end
    tick;
    check("to_err", err, 2'b01);
    check("to_rxv", rx_valid, 0);
    check("to_gnt", gnt, 0);
    req = '0;
    gap_phase;

    // Abandon: owner drops req with nothing pending
    req = 2'b10;
    w = model_pick(req);
    m_ptr = (w + 1) % NREQ;
    tick;
    check("ab_grant", gnt, 32'(1 << w));
    req = '0;
    #1;
    check("ab_ack", byte_ack, 0);
    tick;
    check("ab_gnt", gnt, 0);
    check("ab_busy", busy, 1);
    gap_phase;

    // Reset during WAIT, then pointer back at requester 0
    req = 2'b01;
    w = model_pick(req);
    tick;
    check("rw_grant", gnt, 32'(1 << w));
    byte_valid = 2'b01; byte_last = 2'b00; byte_data = 16'h0042;
    tick;
    byte_valid = '0;
    tick;
    rst = 1'b1;
    #1;
    check("rw_gnt", gnt, 0);
    check("rw_busy", busy, 0);
    check("rw_start", spi_start, 0);
    check("rw_rxv", rx_valid, 0);
    tick;
    rst = 1'b0;
    m_ptr = 0;
    req = 2'b11;
    tx_bytes[0] = 8'h11; rx_bytes[0] = 8'h22;
    run_txn(1, 1'b1);
    req = '0;
    tick;

    // Random request patterns and lengths
    for (int t = 0; t < 6; t++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        tx_bytes[b] = 8'($urandom);
        rx_bytes[b] = 8'($urandom);
      end
      req = NREQ'($urandom_range(1, 3));
      run_txn(nb, 1'b0);
    end
    req = '0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
